// File: rtl/barcode_id_rdr_pkg.sv
// barcode_id_rdr_pkg: shared FSM encodings, station-ID mask and timer defaults for the barcode reader
package barcode_id_rdr_pkg;
    localparam int TMR_W_DEF = 22;
    localparam logic [7:0] ID_VALID_MASK = 8'hC0;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_FALL = 3'd2;
    localparam logic [2:0] SAMPLE    = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    function automatic logic is_station_id(input logic [7:0] id);
        return (id & ID_VALID_MASK) == 8'h00;
    endfunction
endpackage

// File: rtl/bc_sync.sv
// bc_sync: two-flop synchronizer plus edge flop for the idle-high barcode line
module bc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bc,
    output logic bc_s,
    output logic bc_fall
);
    logic meta, prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {meta, bc_s, prev} <= 3'b111;
        else begin
            meta <= bc;
            bc_s <= meta;
            prev <= bc_s;
        end
    assign bc_fall = prev & ~bc_s;
endmodule

// File: rtl/barcode_id_rdr.sv
// barcode_id_rdr: self-clocked serial barcode decoder producing ID / ID_vld for cmd_control
module barcode_id_rdr
    import barcode_id_rdr_pkg::*;
#(
    parameter int               TMR_W   = TMR_W_DEF,
    parameter logic [TMR_W-1:0] TMO_CYC = '1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);
    logic             bc_s, bc_fall;
    logic [2:0]       state;
    logic [TMR_W-1:0] timer, ref_t, timer_inc;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             tmo;

    bc_sync u_sync (.clk(clk), .rst_n(rst_n), .bc(BC), .bc_s(bc_s), .bc_fall(bc_fall));

    assign timer_inc = &timer ? timer : timer + TMR_W'(1);
    // DONE is excluded so a completed frame is never lost to the watchdog
    assign tmo = (TMO_CYC != '0) && state != IDLE && state != DONE && timer == TMO_CYC;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            ref_t   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            ID      <= '0;
            ID_vld  <= 1'b0;
        end else begin
            if (clr_ID_vld) ID_vld <= 1'b0;
            if (tmo) begin
                state <= IDLE;
                timer <= '0;
                shift <= '0;
            end else
                case (state)
                    IDLE: begin
                        timer <= '0;
                        state <= bc_fall ? START : IDLE;
                    end
                    START:
                        if (bc_s) begin
                            ref_t   <= timer;
                            bit_cnt <= '0;
                            timer   <= '0;
                            state   <= (timer == '0) ? IDLE : WAIT_FALL;
                        end else timer <= timer_inc;
                    WAIT_FALL: begin
                        timer <= bc_fall ? '0 : timer_inc;
                        state <= bc_fall ? SAMPLE : WAIT_FALL;
                    end
                    SAMPLE:
                        if (timer == ref_t) begin
                            shift   <= {shift[6:0], bc_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            timer   <= '0;
                            state   <= (bit_cnt == 3'd7) ? DONE : WAIT_FALL;
                        end else timer <= timer_inc;
                    DONE: begin
                        ID     <= shift;
                        ID_vld <= is_station_id(shift);
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: tb/tb_barcode_id_rdr.sv
// tb_barcode_id_rdr: table-driven and randomized frames checked against a frame-level reference model
module tb_barcode_id_rdr;
    typedef struct {
        int         t;
        logic [7:0] d;
        bit         clr_done;
        logic [7:0] exp_id;
        bit         exp_vld;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, bc = 1'b1, clr = 1'b0;
    logic [7:0] id;
    logic       id_vld;
    int         errors = 0, checks = 0;
    logic [7:0] m_id = 8'h00;
    logic       m_vld = 1'b0;
    vec_t       tbl[5];

    always #5 clk = ~clk;

    barcode_id_rdr #(.TMR_W(22), .TMO_CYC(22'd5000)) dut (
        .clk(clk), .rst_n(rst_n), .BC(bc), .clr_ID_vld(clr), .ID(id), .ID_vld(id_vld)
    );

    function automatic bit model_vld(input logic [7:0] d);
        return d[7:6] == 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bit cell = 3t: a '1' is a short low (t/2), a '0' a long low (3t/2); receiver samples t after the fall
    task automatic send_frame(input logic [7:0] d, input int t, input int nbits, input bit clr_done,
                              input logic [7:0] exp_id, input bit exp_vld);
        for (int k = 0; k < 2 * t; k++) begin
            @(negedge clk);
            bc = (k >= t);
        end
        for (int b = 7; b > 7 - nbits; b--) begin
            int low;
            low = d[b] ? t / 2 : (3 * t) / 2;
            for (int k = 0; k < 3 * t; k++) begin
                @(negedge clk);
                bc = (k >= low);
                if (b == 0 && k == t + 3) begin
                    check("pre_done_id", id, m_id);
                    check("pre_done_vld", id_vld, m_vld);
                    clr = clr_done;
                end
                if (b == 0 && k == t + 4) begin
                    clr = 1'b0;
                    check("id", id, exp_id);
                    check("vld", id_vld, exp_vld);
                    m_id  = exp_id;
                    m_vld = exp_vld;
                end
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_vld", id_vld, 1'b0);
        check("clr_id_kept", id, m_id);
        m_vld = 1'b0;
    endtask

    initial begin
        tbl[0] = '{200,  8'h0A, 1'b0, 8'h0A, 1'b1};
        tbl[1] = '{50,   8'h15, 1'b0, 8'h15, 1'b1};
        tbl[2] = '{1000, 8'h3F, 1'b0, 8'h3F, 1'b1};
        tbl[3] = '{100,  8'h4A, 1'b0, 8'h4A, 1'b0};
        tbl[4] = '{40,   8'h05, 1'b1, 8'h05, 1'b1};
        repeat (3) @(negedge clk);
        check("rst_id", id, 8'h00);
        check("rst_vld", id_vld, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].d, tbl[i].t, 8, tbl[i].clr_done, tbl[i].exp_id, tbl[i].exp_vld);
            if (i == 0) pulse_clr();
        end
        // abort a frame with reset after its 4th bit
        send_frame(8'hFF, 60, 4, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_id", id, 8'h00);
        check("async_rst_vld", id_vld, 1'b0);
        m_id  = 8'h00;
        m_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h22, 60, 8, 1'b0, 8'h22, model_vld(8'h22));
        // one-cycle low glitch must not start a frame
        @(negedge clk);
        bc = 1'b0;
        @(negedge clk);
        bc = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_id", id, m_id);
        check("glitch_vld", id_vld, m_vld);
        send_frame(8'h11, 30, 8, 1'b0, 8'h11, model_vld(8'h11));
        // line stuck low past the watchdog
        @(negedge clk);
        bc = 1'b0;
        repeat (6000) @(negedge clk);
        bc = 1'b1;
        repeat (20) @(negedge clk);
        check("tmo_id", id, m_id);
        check("tmo_vld", id_vld, m_vld);
        send_frame(8'h0C, 40, 8, 1'b0, 8'h0C, model_vld(8'h0C));
        for (int i = 0; i < 12; i++) begin
            int         t;
            logic [7:0] d;
            bit         c;
            t = $urandom_range(8, 30);
            d = 8'($urandom);
            c = 1'($urandom_range(0, 1));
            send_frame(d, t, 8, c, d, model_vld(d));
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
